// File: rtl/button_gpio.sv
// button_gpio: eight debounced button/switch inputs with rising-edge flags, irq mask and a 16-bit debounce window.
// Latency: a pin change reaches DATA DEBOUNCE+3 clk edges after it is first sampled; data_out is valid one cycle after rd_strobe.
// Backpressure: none; every read and write strobe is accepted in the cycle it is presented.
module button_gpio #(
  parameter logic [15:0] DEBOUNCE_RST = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        rd_strobe,
  input  logic [3:0]  wr_strobe,
  output logic [31:0] data_out,
  input  logic [7:0]  buttons,
  output logic        irq
);

  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_EDGE     = 2'd1;
  localparam logic [1:0] REG_IRQ_EN   = 2'd2;
  localparam logic [1:0] REG_DEBOUNCE = 2'd3;

  logic [7:0]  sync_meta;
  logic [7:0]  synced;
  logic [7:0]  stable;
  logic [7:0]  edge_flags;
  logic [7:0]  irq_en;
  logic [15:0] debounce;
  logic [15:0] count [8];
  logic [7:0]  commit;
  logic [7:0]  rise;
  logic [7:0]  edge_clr;
  logic [1:0]  sel;
  logic [31:0] rd_val;
  logic        wr_edge;
  logic        wr_irq_en;
  logic        wr_deb_lo;
  logic        wr_deb_hi;
  logic        unused_bits;

  // Only addr[3:2] selects a register; the rest of the bus is don't-care.
  assign sel         = addr[3:2];
  assign unused_bits = ^{addr[31:4], addr[1:0], data_in[31:16], wr_strobe[3:2]};

  assign wr_edge   = wr_strobe[0] && (sel == REG_EDGE);
  assign wr_irq_en = wr_strobe[0] && (sel == REG_IRQ_EN);
  assign wr_deb_lo = wr_strobe[0] && (sel == REG_DEBOUNCE);
  assign wr_deb_hi = wr_strobe[1] && (sel == REG_DEBOUNCE);
  assign edge_clr  = wr_edge ? data_in[7:0] : 8'h00;

  // Two-flop synchronizer in front of everything that looks at the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      synced    <= '0;
    end else begin
      sync_meta <= buttons;
      synced    <= sync_meta;
    end
  end

  // A bit commits once it has disagreed with stable for long enough; >= lets a lowered window commit at once.
  always_comb begin
    commit = '0;
    for (int i = 0; i < 8; i++) begin
      commit[i] = (synced[i] != stable[i]) && (count[i] >= debounce);
    end
  end

  assign rise = commit & synced;

  // Per-bit disagreement counters: cleared on agreement or commit, otherwise counting up.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst) begin
        count[i] <= '0;
      end else if ((synced[i] == stable[i]) || commit[i]) begin
        count[i] <= '0;
      end else begin
        count[i] <= count[i] + 16'd1;
      end
    end
  end

  // Debounced level; committing bits simply toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= '0;
    end else begin
      stable <= stable ^ commit;
    end
  end

  // Rising-edge flags: write-one-to-clear, with a same-cycle rise overriding the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_flags <= '0;
    end else begin
      edge_flags <= (edge_flags & ~edge_clr) | rise;
    end
  end

  // Control registers with byte-lane enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= '0;
      debounce <= DEBOUNCE_RST;
    end else begin
      if (wr_irq_en) irq_en         <= data_in[7:0];
      if (wr_deb_lo) debounce[7:0]  <= data_in[7:0];
      if (wr_deb_hi) debounce[15:8] <= data_in[15:8];
    end
  end

  // Read mux over the current (pre-write) register values; unused upper bits read as zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_DATA:     rd_val = {24'h0, stable};
      REG_EDGE:     rd_val = {24'h0, edge_flags};
      REG_IRQ_EN:   rd_val = {24'h0, irq_en};
      REG_DEBOUNCE: rd_val = {16'h0, debounce};
      default:      rd_val = '0;
    endcase
  end

  // Read data is captured on the strobe edge and held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_strobe) begin
      data_out <= rd_val;
    end
  end

  assign irq = |(edge_flags & irq_en);

endmodule

// File: doc/button_gpio.md
BUTTON_GPIO -- requirements
Module: button_gpio

Interface
REQ-001 SHALL have parameter DEBOUNCE_RST, default 16'd1000, reset value of the DEBOUNCE register.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port addr  input  32  register select; only addr[3:2] is decoded, all other bits are ignored.
REQ-005 SHALL have port data_in  input  32  write data.
REQ-006 SHALL have port rd_strobe  input  1  read request, one cycle per read.
REQ-007 SHALL have port wr_strobe  input  4  byte-lane write enables; bit n enables data_in[8n+7:8n].
REQ-008 SHALL have port data_out  output  32  registered read data.
REQ-009 SHALL have port buttons  input  8  asynchronous button/switch pins.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL decode the register map as: addr[3:2]=0 DATA (RO, 8b debounced level); 1 EDGE (W1C, 8b rising-edge flags); 2 IRQ_EN (RW, 8b); 3 DEBOUNCE (RW, 16b).
REQ-012 SHALL pass each buttons bit through a 2-flop synchronizer before any other logic uses it.
REQ-013 SHALL give each bit its own 16-bit counter; when synced == stable, counter <= 0.
REQ-014 SHALL, when synced != stable and counter >= DEBOUNCE, set stable <= synced and counter <= 0; otherwise counter <= counter+1.
REQ-015 SHALL use the >= compare so that lowering DEBOUNCE below an in-flight count commits on the next cycle (no wrap-around).
REQ-016 SHALL update DATA after exactly DEBOUNCE+3 clk edges, counted from the first edge that samples the pin at its new level, provided the pin holds that level throughout.
REQ-017 SHALL discard any glitch shorter than that window: the counter clears and DATA is unchanged.
REQ-018 SHALL set EDGE[i] in the same cycle that stable[i] goes 0->1; falling transitions do not set it.
REQ-019 SHALL clear EDGE[i] on a write to EDGE with wr_strobe[0]=1 and data_in[i]=1; writing 0 leaves the bit unchanged.
REQ-020 SHALL let the set win when a set and a clear of EDGE[i] happen in the same cycle; the bit stays 1.
REQ-021 SHALL drive irq = |(EDGE & IRQ_EN) combinationally from the registers, with no added latency.
REQ-022 SHALL honour byte lanes on writes: IRQ_EN uses lane 0; DEBOUNCE uses lane 0 for [7:0] and lane 1 for [15:8]; other lanes are ignored; writes to DATA have no effect.
REQ-023 SHALL capture the selected register into data_out on the edge where rd_strobe=1; data_out is valid the next cycle and holds its value until the next read.
REQ-024 SHALL return unimplemented upper bits as 0 on reads.
REQ-025 SHALL, when a read and a write hit the same register in the same cycle, perform both, with data_out returning the pre-write value.
REQ-026 SHALL have no read side effects; reading EDGE does not clear it.

Reset
REQ-027 SHALL, on rst=1, set synchronizer flops, stable, all counters, EDGE, IRQ_EN and data_out to 0, and DEBOUNCE to DEBOUNCE_RST.
REQ-028 SHALL give rst priority over every simultaneous read, write and debounce event.
REQ-029 SHALL hold irq at 0 from the first cycle after reset.
REQ-030 SHALL treat a pin held high through reset as a new 0->1 transition after reset: it is debounced and sets EDGE normally.

Verification
REQ-031 Bench SHALL cover: DEBOUNCE=0, buttons[0] 0->1 held -> DATA[0]=1 and EDGE[0]=1 exactly 3 edges later; read DATA -> data_out=32'h1 one cycle after rd_strobe.
REQ-032 Bench SHALL cover: DEBOUNCE=10, buttons[3] high for 5 cycles then low -> DATA and EDGE remain 0, irq=0.
REQ-033 Bench SHALL cover: IRQ_EN=8'h04, rising edge on buttons[2] -> irq=1; write EDGE with 32'h04 -> irq=0 the next cycle; write 32'h00 -> no change.
REQ-034 Bench SHALL cover: W1C on EDGE[1] in the same cycle stable[1] rises -> EDGE[1] stays 1.
REQ-035 Bench SHALL cover: write DEBOUNCE=32'h0000_1234 with wr_strobe=4'b0001 after reset -> DEBOUNCE reads 16'h0334 (DEBOUNCE_RST=1000=16'h03E8, so the upper byte stays 0x03).
REQ-036 Bench SHALL cover: assert rst mid-debounce with buttons=8'hFF -> all registers reset, DEBOUNCE=1000, then DATA=8'hFF and EDGE=8'hFF after 1003 edges.
